dest_ip_filter_tbl_ctrl: RTL and testbench



---
 rtl/dest_ip_filter_tbl_ctrl_pkg.sv | 22 ++
 rtl/dest_ip_filter_tbl_ctrl_if.sv | 49 ++++
 rtl/dest_ip_filter_tbl_ctrl_arb.sv | 39 +++
 rtl/dest_ip_filter_tbl_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dest_ip_filter_tbl_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dest_ip_filter_tbl_ctrl_pkg.sv
// Shared types and constants for the destination-IP filter table controller.
// State encoding is fixed so that a debug probe of o_dbg_state decodes directly.
package dest_ip_filter_tbl_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOST_RD = 2'd1,
        ST_HOST_WR = 2'd2,
        ST_CLR_WR  = 2'd3
    } state_t;

    // Returned to the host when a table read never gets an ack.
    localparam logic [31:0] TMO_RD_IP = 32'hDEAD_BEEF;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dest_ip_filter_tbl_ctrl_if.sv
// Host-side and table-side bundles of the filter table controller.
// Handshake: req is a level held until the matching single-cycle ack; the requester drops req in the ack cycle.
interface dest_ip_filter_host_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] host_rd_addr;
    logic              host_rd_req;
    logic [31:0]       host_rd_ip;
    logic              host_rd_ack;
    logic [ADDR_W-1:0] host_wr_addr;
    logic              host_wr_req;
    logic [31:0]       host_wr_ip;
    logic              host_wr_ack;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic              timeout_err;

    modport master (
        output host_rd_addr, host_rd_req, host_wr_addr, host_wr_req, host_wr_ip, clear_start,
        input  host_rd_ip, host_rd_ack, host_wr_ack, clear_busy, clear_done, timeout_err
    );
    modport slave (
        input  host_rd_addr, host_rd_req, host_wr_addr, host_wr_req, host_wr_ip, clear_start,
        output host_rd_ip, host_rd_ack, host_wr_ack, clear_busy, clear_done, timeout_err
    );
endinterface

interface dest_ip_filter_tbl_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] tbl_rd_addr;
    logic              tbl_rd_req;
    logic [31:0]       tbl_rd_ip;
    logic              tbl_rd_ack;
    logic [ADDR_W-1:0] tbl_wr_addr;
    logic              tbl_wr_req;
    logic [31:0]       tbl_wr_ip;
    logic              tbl_wr_ack;

    modport master (
        output tbl_rd_addr, tbl_rd_req, tbl_wr_addr, tbl_wr_req, tbl_wr_ip,
        input  tbl_rd_ip, tbl_rd_ack, tbl_wr_ack
    );
    modport slave (
        input  tbl_rd_addr, tbl_rd_req, tbl_wr_addr, tbl_wr_req, tbl_wr_ip,
        output tbl_rd_ip, tbl_rd_ack, tbl_wr_ack
    );
endinterface

// File: rtl/dest_ip_filter_tbl_ctrl_arb.sv
// Two-way round-robin arbiter between host ops and the clear sweep.
// On a tie the requester that did not win last time is granted.
module dest_ip_filter_tbl_arb (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req_host,
    input  logic i_req_clr,
    output logic o_gnt_host,
    output logic o_gnt_clr
);

    logic r_last_clr;

    always_comb begin
        o_gnt_host = 1'b0;
        o_gnt_clr  = 1'b0;
        if (i_en) begin
            if (i_req_host && i_req_clr) begin
                o_gnt_host = r_last_clr;
                o_gnt_clr  = !r_last_clr;
            end else begin
                o_gnt_host = i_req_host;
                o_gnt_clr  = i_req_clr;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_clr <= 1'b0;
        end else if (o_gnt_host) begin
            r_last_clr <= 1'b0;
        end else if (o_gnt_clr) begin
            r_last_clr <= 1'b1;
        end
    end

endmodule

// File: rtl/dest_ip_filter_tbl_ctrl.sv
// Serialises host reads/writes and a clear-all sweep onto the filter table ports,
// one table op in flight at a time, each bounded by an ack timeout.
module dest_ip_filter_tbl_ctrl
    import dest_ip_filter_tbl_ctrl_pkg::*;
#(
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = clog2(LUT_DEPTH),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    dest_ip_filter_host_if.slave  host,
    dest_ip_filter_tbl_if.master  tbl,
    output state_t                o_dbg_state
);

    localparam int                        TMO_W    = clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]          TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LUT_DEPTH_BITS-1:0] PTR_LAST = LUT_DEPTH_BITS'(LUT_DEPTH - 1);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [TMO_W-1:0]          r_tmo_cnt;
    logic [LUT_DEPTH_BITS-1:0] r_clr_ptr;
    logic                      r_clear_busy;
    logic                      r_clear_done;
    logic                      r_timeout_err;
    logic                      r_host_rd_ack;
    logic                      r_host_wr_ack;
    logic [31:0]               r_host_rd_ip;
    logic [LUT_DEPTH_BITS-1:0] r_tbl_rd_addr;
    logic                      r_tbl_rd_req;
    logic [LUT_DEPTH_BITS-1:0] r_tbl_wr_addr;
    logic                      r_tbl_wr_req;
    logic [31:0]               r_tbl_wr_ip;

    logic w_wr_pend, w_rd_pend, w_in_idle, w_gnt_host, w_gnt_clr;
    logic w_rd_ack, w_wr_ack, w_tmo;

    // A req still high during its own ack cycle is the old request, not a new one.
    assign w_wr_pend = host.host_wr_req && !r_host_wr_ack;
    assign w_rd_pend = host.host_rd_req && !r_host_rd_ack;
    assign w_in_idle = (r_state == ST_IDLE);
    assign w_rd_ack  = (r_state == ST_HOST_RD) && tbl.tbl_rd_ack;
    assign w_wr_ack  = ((r_state == ST_HOST_WR) || (r_state == ST_CLR_WR)) && tbl.tbl_wr_ack;
    assign w_tmo     = !w_in_idle && (r_tmo_cnt == TMO_LAST);

    dest_ip_filter_tbl_arb u_arb (
        .i_clk      (clk),
        .i_rst_n    (resetn),
        .i_en       (w_in_idle),
        .i_req_host (w_wr_pend || w_rd_pend),
        .i_req_clr  (r_clear_busy),
        .o_gnt_host (w_gnt_host),
        .o_gnt_clr  (w_gnt_clr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_host)     w_next_state = w_wr_pend ? ST_HOST_WR : ST_HOST_RD;
                else if (w_gnt_clr) w_next_state = ST_CLR_WR;
            end
            ST_HOST_RD:            if (w_rd_ack || w_tmo) w_next_state = ST_IDLE;
            ST_HOST_WR, ST_CLR_WR: if (w_wr_ack || w_tmo) w_next_state = ST_IDLE;
            default:               w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt     <= '0;
            r_clr_ptr     <= '0;
            r_clear_busy  <= 1'b0;
            r_clear_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_host_rd_ack <= 1'b0;
            r_host_wr_ack <= 1'b0;
            r_host_rd_ip  <= '0;
            r_tbl_rd_addr <= '0;
            r_tbl_rd_req  <= 1'b0;
            r_tbl_wr_addr <= '0;
            r_tbl_wr_req  <= 1'b0;
            r_tbl_wr_ip   <= '0;
        end else begin
            r_host_rd_ack <= 1'b0;
            r_host_wr_ack <= 1'b0;
            r_clear_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tmo_cnt     <= w_in_idle ? '0 : r_tmo_cnt + 1'b1;

            if (host.clear_start && !r_clear_busy) begin
                r_clear_busy <= 1'b1;
                r_clr_ptr    <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_host && w_wr_pend) begin
                        r_tbl_wr_addr <= host.host_wr_addr;
                        r_tbl_wr_ip   <= host.host_wr_ip;
                        r_tbl_wr_req  <= 1'b1;
                    end else if (w_gnt_host) begin
                        r_tbl_rd_addr <= host.host_rd_addr;
                        r_tbl_rd_req  <= 1'b1;
                    end else if (w_gnt_clr) begin
                        r_tbl_wr_addr <= r_clr_ptr;
                        r_tbl_wr_ip   <= '0;
                        r_tbl_wr_req  <= 1'b1;
                    end
                end
                ST_HOST_RD: begin
                    // An ack landing on the terminal count wins over the timeout.
                    if (w_rd_ack || w_tmo) begin
                        r_tbl_rd_req  <= 1'b0;
                        r_host_rd_ack <= 1'b1;
                        r_host_rd_ip  <= w_rd_ack ? tbl.tbl_rd_ip : TMO_RD_IP;
                        r_timeout_err <= !w_rd_ack;
                    end
                end
                ST_HOST_WR: begin
                    if (w_wr_ack || w_tmo) begin
                        r_tbl_wr_req  <= 1'b0;
                        r_host_wr_ack <= 1'b1;
                        r_timeout_err <= !w_wr_ack;
                    end
                end
                ST_CLR_WR: begin
                    if (w_wr_ack) begin
                        r_tbl_wr_req <= 1'b0;
                        if (r_clr_ptr == PTR_LAST) begin
                            r_clear_busy <= 1'b0;
                            r_clear_done <= 1'b1;
                            r_clr_ptr    <= '0;
                        end else begin
                            r_clr_ptr <= r_clr_ptr + 1'b1;
                        end
                    end else if (w_tmo) begin
                        r_tbl_wr_req  <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_clear_busy  <= 1'b0;
                        r_clr_ptr     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign host.host_rd_ip  = r_host_rd_ip;
    assign host.host_rd_ack = r_host_rd_ack;
    assign host.host_wr_ack = r_host_wr_ack;
    assign host.clear_busy  = r_clear_busy;
    assign host.clear_done  = r_clear_done;
    assign host.timeout_err = r_timeout_err;
    assign tbl.tbl_rd_addr  = r_tbl_rd_addr;
    assign tbl.tbl_rd_req   = r_tbl_rd_req;
    assign tbl.tbl_wr_addr  = r_tbl_wr_addr;
    assign tbl.tbl_wr_req   = r_tbl_wr_req;
    assign tbl.tbl_wr_ip    = r_tbl_wr_ip;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_dest_ip_filter_tbl_ctrl.sv
// Directed bench for dest_ip_filter_tbl_ctrl: a behavioural filter table with
// programmable ack latency, host driver tasks and a write-log scoreboard.
module tb_dest_ip_filter_tbl_ctrl;
    import dest_ip_filter_tbl_ctrl_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int TMO   = 64;
    localparam int BOUND = 300;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    dest_ip_filter_host_if #(.ADDR_W(AW)) h ();
    dest_ip_filter_tbl_if  #(.ADDR_W(AW)) t ();
    state_t dbg_state;

    dest_ip_filter_tbl_ctrl #(
        .LUT_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .host        (h),
        .tbl         (t),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_miscompare = 0;
    logic [31:0] mem [DEPTH];
    logic [AW+31:0] wr_log [$];
    logic [AW+31:0] exp_q [$];
    int wr_delay = 1, rd_delay = 1;
    bit rd_mute = 1'b0;
    int wr_cnt = 0, rd_cnt = 0, cyc = 0;
    int wr_req_hi = 0, rd_req_hi = 0;
    int cnt_wr_ack = 0, cnt_rd_ack = 0, cnt_done = 0, cnt_tmo = 0, cnt_tmo_rdack = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_len"}, 64'(wr_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check_eq($sformatf("%s_w%0d", tag, i), 64'(wr_log[i]), 64'(exp_q[i]));
        wr_log.delete();
        exp_q.delete();
    endtask

    // ---------------- filter table model ----------------
    initial begin
        t.tbl_rd_ack = 1'b0;
        t.tbl_wr_ack = 1'b0;
        t.tbl_rd_ip  = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            t.tbl_wr_ack = 1'b0;
            t.tbl_rd_ack = 1'b0;
            if (t.tbl_wr_req) begin
                wr_cnt++;
                if (wr_cnt >= wr_delay) begin
                    t.tbl_wr_ack = 1'b1;
                    mem[t.tbl_wr_addr] = t.tbl_wr_ip;
                    wr_log.push_back({t.tbl_wr_addr, t.tbl_wr_ip});
                    wr_cnt = 0;
                end
            end else begin
                wr_cnt = 0;
            end
            if (t.tbl_rd_req && !rd_mute) begin
                rd_cnt++;
                if (rd_cnt >= rd_delay) begin
                    t.tbl_rd_ack = 1'b1;
                    t.tbl_rd_ip  = mem[t.tbl_rd_addr];
                    rd_cnt = 0;
                end
            end else begin
                rd_cnt = 0;
            end
        end
    end

    // ---------------- output monitor ----------------
    initial forever begin
        @(negedge clk);
        if (t.tbl_wr_req)   wr_req_hi++;
        if (t.tbl_rd_req)   rd_req_hi++;
        if (h.host_wr_ack)  cnt_wr_ack++;
        if (h.host_rd_ack)  cnt_rd_ack++;
        if (h.clear_done)   cnt_done++;
        if (h.timeout_err)  cnt_tmo++;
        if (h.timeout_err && h.host_rd_ack) cnt_tmo_rdack++;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- driver tasks ----------------
    // Host inputs are scrambled once the op is granted to prove they were latched.
    task automatic host_write(input logic [AW-1:0] a, input logic [31:0] ip, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        h.host_wr_addr = a;
        h.host_wr_ip   = ip;
        h.host_wr_req  = 1'b1;
        for (int n = 0; n < BOUND; n++) begin
            @(posedge clk); #1;
            if (h.host_wr_ack) begin ok = 1'b1; break; end
            if (dbg_state == ST_HOST_WR) begin
                h.host_wr_addr = ~a;
                h.host_wr_ip   = ~ip;
            end
        end
        h.host_wr_req = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [31:0] ip, output bit ok);
        ok = 1'b0;
        ip = '0;
        @(negedge clk);
        h.host_rd_addr = a;
        h.host_rd_req  = 1'b1;
        for (int n = 0; n < BOUND; n++) begin
            @(posedge clk); #1;
            if (h.host_rd_ack) begin ok = 1'b1; ip = h.host_rd_ip; break; end
            if (dbg_state == ST_HOST_RD) h.host_rd_addr = ~a;
        end
        h.host_rd_req = 1'b0;
    endtask

    task automatic host_rdwr(input logic [AW-1:0] wa, input logic [31:0] wip, input logic [AW-1:0] ra,
                             output logic [31:0] rip, output int wr_at, output int rd_at, output bit ok);
        bit wr_done, rd_done;
        wr_done = 1'b0; rd_done = 1'b0; wr_at = 0; rd_at = 0; rip = '0;
        @(negedge clk);
        h.host_wr_addr = wa; h.host_wr_ip = wip; h.host_wr_req = 1'b1;
        h.host_rd_addr = ra; h.host_rd_req = 1'b1;
        for (int n = 0; n < BOUND && !(wr_done && rd_done); n++) begin
            @(posedge clk); #1;
            if (h.host_wr_ack && !wr_done) begin wr_done = 1'b1; wr_at = cyc; h.host_wr_req = 1'b0; end
            if (h.host_rd_ack && !rd_done) begin
                rd_done = 1'b1; rd_at = cyc; rip = h.host_rd_ip; h.host_rd_req = 1'b0;
            end
        end
        h.host_wr_req = 1'b0;
        h.host_rd_req = 1'b0;
        ok = wr_done && rd_done;
    endtask

    task automatic pulse_clear();
        @(negedge clk); h.clear_start = 1'b1;
        @(negedge clk); h.clear_start = 1'b0;
    endtask

    task automatic wait_clear_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (h.clear_done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_sweep_at(input logic [AW-1:0] a, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (dbg_state == ST_CLR_WR && t.tbl_wr_addr == a) begin ok = 1'b1; break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rip;
        bit ok, restarted;
        int base, base2, busy_drop, wr_at, rd_at;

        resetn = 1'b0;
        h.host_rd_addr = '0; h.host_rd_req = 1'b0;
        h.host_wr_addr = '0; h.host_wr_req = 1'b0; h.host_wr_ip = '0;
        h.clear_start  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctl", 64'({h.host_rd_ack, h.host_wr_ack, h.clear_busy, h.clear_done,
                                 h.timeout_err, t.tbl_rd_req, t.tbl_wr_req}), 64'(0));
        check_eq("rst_data", 64'({t.tbl_rd_addr, t.tbl_wr_addr, t.tbl_wr_ip}), 64'(0));
        check_eq("rst_rd_ip", 64'(h.host_rd_ip), 64'(0));
        check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk); resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Host write then read back, filter latency 3 on writes.
        wr_log.delete();
        wr_delay = 3; wr_req_hi = 0; base = cnt_wr_ack;
        host_write(5'd5, 32'h0A00_0001, ok);
        check_eq("t1_wr_ack", 64'(ok), 64'(1));
        repeat (2) @(negedge clk);
        check_eq("t1_wr_req_cycles", 64'(wr_req_hi), 64'(3));
        check_eq("t1_wr_ack_pulses", 64'(cnt_wr_ack - base), 64'(1));
        exp_q.push_back({5'd5, 32'h0A00_0001});
        check_log("t1");
        rd_delay = 2; base = cnt_rd_ack;
        host_read(5'd5, rip, ok);
        check_eq("t1_rd_ack", 64'(ok), 64'(1));
        check_eq("t1_rd_ip", 64'(rip), 64'(32'h0A00_0001));
        repeat (2) @(negedge clk);
        check_eq("t1_rd_ack_pulses", 64'(cnt_rd_ack - base), 64'(1));

        // Clear sweep, second clear_start mid-sweep must not restart it.
        wr_log.delete();
        wr_delay = 1; base = cnt_done; busy_drop = 0; restarted = 1'b0; ok = 1'b0;
        @(negedge clk); h.clear_start = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (wr_log.size() == 20 && !restarted) begin
                h.clear_start = 1'b1; restarted = 1'b1;
            end else begin
                h.clear_start = 1'b0;
            end
            if (h.clear_done) begin ok = 1'b1; break; end
            if (!h.clear_busy) busy_drop++;
        end
        h.clear_start = 1'b0;
        check_eq("t2_done_seen", 64'(ok), 64'(1));
        check_eq("t2_busy_drops", 64'(busy_drop), 64'(0));
        repeat (4) @(negedge clk);
        check_eq("t2_done_pulses", 64'(cnt_done - base), 64'(1));
        check_eq("t2_busy_after", 64'(h.clear_busy), 64'(0));
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), 32'h0});
        check_log("t2");
        host_read(5'd5, rip, ok);
        check_eq("t2_rd_cleared", 64'(rip), 64'(0));

        // Host write arriving while the sweep is on entry 10.
        wr_log.delete();
        wr_delay = 2; base = cnt_done;
        pulse_clear();
        wait_sweep_at(5'd10, ok);
        check_eq("t3_reach10", 64'(ok), 64'(1));
        host_write(5'd7, 32'hC0A8_0101, ok);
        check_eq("t3_wr_ack", 64'(ok), 64'(1));
        wait_clear_done(ok);
        check_eq("t3_done_seen", 64'(ok), 64'(1));
        repeat (3) @(negedge clk);
        check_eq("t3_done_pulses", 64'(cnt_done - base), 64'(1));
        for (int i = 0; i <= 10; i++) exp_q.push_back({AW'(i), 32'h0});
        exp_q.push_back({5'd7, 32'hC0A8_0101});
        for (int i = 11; i < DEPTH; i++) exp_q.push_back({AW'(i), 32'h0});
        check_log("t3");

        // Simultaneous read and write of the same entry: write goes first.
        wr_log.delete();
        wr_delay = 1; rd_delay = 1;
        host_rdwr(5'd9, 32'h1122_3344, 5'd9, rip, wr_at, rd_at, ok);
        check_eq("t4_both_acked", 64'(ok), 64'(1));
        check_eq("t4_wr_before_rd", 64'(wr_at < rd_at), 64'(1));
        check_eq("t4_rd_ip", 64'(rip), 64'(32'h1122_3344));
        exp_q.push_back({5'd9, 32'h1122_3344});
        check_log("t4");

        // Read that is never acked times out after 64 cycles.
        rd_mute = 1'b1; rd_req_hi = 0; base = cnt_tmo; base2 = cnt_tmo_rdack;
        host_read(5'd3, rip, ok);
        check_eq("t5_rd_ack", 64'(ok), 64'(1));
        check_eq("t5_rd_ip", 64'(rip), 64'(32'hDEAD_BEEF));
        repeat (2) @(negedge clk);
        check_eq("t5_rd_req_cycles", 64'(rd_req_hi), 64'(64));
        check_eq("t5_tmo_pulses", 64'(cnt_tmo - base), 64'(1));
        check_eq("t5_tmo_with_ack", 64'(cnt_tmo_rdack - base2), 64'(1));
        rd_mute = 1'b0;

        // Ack on the terminal count still counts as success.
        rd_delay = 64; mem[4] = 32'h55AA_55AA; base = cnt_tmo;
        host_read(5'd4, rip, ok);
        check_eq("t5b_rd_ack", 64'(ok), 64'(1));
        check_eq("t5b_rd_ip", 64'(rip), 64'(32'h55AA_55AA));
        repeat (2) @(negedge clk);
        check_eq("t5b_no_tmo", 64'(cnt_tmo - base), 64'(0));
        rd_delay = 1;

        // Reset in the middle of a sweep.
        wr_delay = 1;
        pulse_clear();
        wait_sweep_at(5'd7, ok);
        check_eq("t6_reach7", 64'(ok), 64'(1));
        resetn = 1'b0;
        #1;
        check_eq("t6_rst_ctl", 64'({h.clear_busy, h.clear_done, h.timeout_err,
                                    t.tbl_rd_req, t.tbl_wr_req}), 64'(0));
        check_eq("t6_rst_addr", 64'(t.tbl_wr_addr), 64'(0));
        check_eq("t6_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        wr_log.delete();
        repeat (40) @(negedge clk);
        check_eq("t6_no_writes", 64'(wr_log.size()), 64'(0));
        check_eq("t6_busy_low", 64'(h.clear_busy), 64'(0));
        check_eq("t6_idle", 64'(dbg_state), 64'(ST_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
